// File: rtl/fat32_dir_sector_writer.sv
// rtl/fat32_dir_sector_writer.sv - streams one FAT32 directory sector holding an 8.3 entry for the log file.
// Optional FAT32_DIR_PRESERVE_EN: non-entry bytes are copied from srcByte instead of zero.
module fat32_dir_sector_writer #(
  parameter int          SECTOR_BYTES = 512,
  parameter int          INDEX_WIDTH  = 9,
  parameter logic [87:0] FILE_NAME    = "SAVEDATADAT",
  parameter logic [15:0] FILE_DATE    = 16'h0021
) (
  input  logic                   Clock,
  input  logic                   sys_rst,
  input  logic                   start,
  input  logic [3:0]             entrySlot,
  input  logic [31:0]            firstCluster,
  input  logic [31:0]            fileSize,
  output logic                   busy,
  output logic                   done,
  output logic                   byteValid,
  input  logic                   byteReady,
  output logic [INDEX_WIDTH-1:0] byteAddress,
  output logic [7:0]             byteData,
  output logic [INDEX_WIDTH-1:0] srcAddress,
  input  logic [7:0]             srcByte
);

  localparam logic [INDEX_WIDTH-1:0] LAST_ADDR = INDEX_WIDTH'(SECTOR_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] addr_q;
  logic [3:0]             slot_q;
  logic [27:0]            cluster_q;
  logic [31:0]            size_q;
  logic [7:0]             entry_byte;
  logic [7:0]             fill_byte;
  logic                   in_entry;

  always_ff @(posedge Clock or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      slot_q    <= '0;
      cluster_q <= '0;
      size_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        slot_q    <= entrySlot;
        cluster_q <= firstCluster[27:0];
        size_q    <= fileSize;
        addr_q    <= '0;
      end else if (state_q == S_EMIT && byteReady) begin
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_EMIT;
      S_EMIT:  if (byteReady && addr_q == LAST_ADDR) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Directory entry layout, all multi-byte fields little-endian.
  always_comb begin
    entry_byte = 8'h00;
    case (addr_q[4:0])
      5'd0:  entry_byte = FILE_NAME[87:80];
      5'd1:  entry_byte = FILE_NAME[79:72];
      5'd2:  entry_byte = FILE_NAME[71:64];
      5'd3:  entry_byte = FILE_NAME[63:56];
      5'd4:  entry_byte = FILE_NAME[55:48];
      5'd5:  entry_byte = FILE_NAME[47:40];
      5'd6:  entry_byte = FILE_NAME[39:32];
      5'd7:  entry_byte = FILE_NAME[31:24];
      5'd8:  entry_byte = FILE_NAME[23:16];
      5'd9:  entry_byte = FILE_NAME[15:8];
      5'd10: entry_byte = FILE_NAME[7:0];
      5'd11: entry_byte = 8'h20;
      5'd16, 5'd18, 5'd24: entry_byte = FILE_DATE[7:0];
      5'd17, 5'd19, 5'd25: entry_byte = FILE_DATE[15:8];
      5'd20: entry_byte = cluster_q[23:16];
      5'd21: entry_byte = {4'h0, cluster_q[27:24]};
      5'd26: entry_byte = cluster_q[7:0];
      5'd27: entry_byte = cluster_q[15:8];
      5'd28: entry_byte = size_q[7:0];
      5'd29: entry_byte = size_q[15:8];
      5'd30: entry_byte = size_q[23:16];
      5'd31: entry_byte = size_q[31:24];
      default: entry_byte = 8'h00;
    endcase
  end

  assign in_entry    = (addr_q[INDEX_WIDTH-1:5] == slot_q);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign byteValid   = (state_q == S_EMIT);
  assign byteAddress = addr_q;
  assign byteData    = byteValid ? (in_entry ? entry_byte : fill_byte) : 8'h00;

`ifdef FAT32_DIR_PRESERVE_EN
  logic unused_bits;
  assign unused_bits = ^firstCluster[31:28];
  assign srcAddress  = byteValid ? addr_q : '0;
  assign fill_byte   = srcByte;
`else
  logic unused_bits;
  assign unused_bits = ^{firstCluster[31:28], srcByte};
  assign srcAddress  = '0;
  assign fill_byte   = 8'h00;
`endif

endmodule

// File: tb/tb_fat32_dir_sector_writer.sv
// tb/tb_fat32_dir_sector_writer.sv - randomized self-checking bench against a byte-array sector model.
module tb_fat32_dir_sector_writer;

  logic        Clock = 1'b0;
  logic        sys_rst;
  logic        start;
  logic [3:0]  entrySlot;
  logic [31:0] firstCluster;
  logic [31:0] fileSize;
  logic        busy, done, byteValid, byteReady;
  logic [8:0]  byteAddress, srcAddress;
  logic [7:0]  byteData, srcByte;

  int checks = 0;
  int errors = 0;
  logic [7:0] model [512];
  logic [7:0] cap   [512];

  fat32_dir_sector_writer dut (
    .Clock(Clock), .sys_rst(sys_rst), .start(start), .entrySlot(entrySlot),
    .firstCluster(firstCluster), .fileSize(fileSize), .busy(busy), .done(done),
    .byteValid(byteValid), .byteReady(byteReady), .byteAddress(byteAddress),
    .byteData(byteData), .srcAddress(srcAddress), .srcByte(srcByte)
  );

  always #5 Clock = ~Clock;
  assign srcByte = srcAddress[7:0] ^ 8'hA5;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic build_model(input logic [3:0] slot, input logic [31:0] clus, input logic [31:0] size);
    string nm = "SAVEDATADAT";
    int base = slot * 32;
    int cl = clus & 32'h0FFF_FFFF;
    for (int i = 0; i < 512; i++) begin
`ifdef FAT32_DIR_PRESERVE_EN
      model[i] = (i % 256) ^ 8'hA5;
`else
      model[i] = 8'h00;
`endif
    end
    for (int j = 0; j < 32; j++) model[base + j] = 8'h00;
    for (int j = 0; j < 11; j++) model[base + j] = nm[j];
    model[base + 11] = 8'h20;
    model[base + 16] = 8'h21;
    model[base + 18] = 8'h21;
    model[base + 24] = 8'h21;
    model[base + 20] = (cl / 65536) % 256;
    model[base + 21] = cl / 16777216;
    model[base + 26] = cl % 256;
    model[base + 27] = (cl / 256) % 256;
    for (int j = 0; j < 4; j++) model[base + 28 + j] = (size >> (8 * j)) & 32'hFF;
  endtask

  // Caller is 1 time unit after a rising edge with the DUT idle.
  task automatic run_sector(input logic [3:0] slot, input logic [31:0] clus, input logic [31:0] size,
                            input bit rnd_ready, input bit poke, input int reset_at);
    int  k = 1;
    int  exp_addr = 0;
    int  done_cnt = 0;
    bit  stalled = 0;
    logic [7:0] prev_data = 8'h00;
    bit  r;
    build_model(slot, clus, size);
    entrySlot = slot; firstCluster = clus; fileSize = size;
    start = 1'b1; byteReady = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    check("n1_busy", {31'b0, busy}, 1);
    check("n1_valid", {31'b0, byteValid}, 1);
    check("n1_addr", {23'b0, byteAddress}, 0);
    forever begin
      if (k > 4000) begin
        check("sector_timeout", exp_addr, 512);
        break;
      end
      if (done) begin
        done_cnt++;
        if (!rnd_ready) check("done_cycle", k, 513);
        start = 1'b0;
        byteReady = 1'b0;
        @(posedge Clock); #1;
        check("post_done_busy", {31'b0, busy}, 0);
        check("post_done_done", {31'b0, done}, 0);
        break;
      end
      if (byteValid) begin
        if (reset_at >= 0 && int'(byteAddress) == reset_at) begin
          sys_rst = 1'b1;
          #1;
          check("rst_valid", {31'b0, byteValid}, 0);
          check("rst_busy", {31'b0, busy}, 0);
          check("rst_addr", {23'b0, byteAddress}, 0);
          check("rst_data", {24'b0, byteData}, 0);
          for (int c = 0; c < 2; c++) begin
            @(posedge Clock); #1;
            check("rst_no_done", {31'b0, done}, 0);
          end
          sys_rst = 1'b0;
          for (int c = 0; c < 3; c++) begin
            @(posedge Clock); #1;
            check("after_rst_done", {31'b0, done}, 0);
            check("after_rst_busy", {31'b0, busy}, 0);
          end
          return;
        end
        check("addr_seq", {23'b0, byteAddress}, exp_addr);
        check($sformatf("data@%0d", byteAddress), {24'b0, byteData}, {24'b0, model[byteAddress]});
        if (stalled) check("stall_stable", {24'b0, byteData}, {24'b0, prev_data});
`ifdef FAT32_DIR_PRESERVE_EN
        check("src_addr", {23'b0, srcAddress}, {23'b0, byteAddress});
`else
        check("src_addr_zero", {23'b0, srcAddress}, 0);
`endif
        r = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        byteReady = r;
        prev_data = byteData;
        stalled = !r;
        if (r) begin
          cap[byteAddress] = byteData;
          exp_addr++;
        end
      end
      if (poke && $urandom_range(0, 5) == 0) begin
        start = 1'b1;
        entrySlot = 4'($urandom);
        firstCluster = $urandom;
        fileSize = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge Clock); #1;
      k++;
    end
    check("bytes_moved", exp_addr, 512);
    check("done_pulses", done_cnt, 1);
  endtask

  initial begin
    sys_rst = 1'b1; start = 1'b1; byteReady = 1'b1;
    entrySlot = 4'd3; firstCluster = 32'h1234; fileSize = 32'h10;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_busy0", {31'b0, busy}, 0);
    check("rst_done0", {31'b0, done}, 0);
    check("rst_valid0", {31'b0, byteValid}, 0);
    check("rst_addr0", {23'b0, byteAddress}, 0);
    check("rst_src0", {23'b0, srcAddress}, 0);
    check("rst_data0", {24'b0, byteData}, 0);
    sys_rst = 1'b0; start = 1'b0;
    @(posedge Clock); #1;
    check("start_in_rst_ignored", {31'b0, busy}, 0);

    run_sector(4'd0, 32'h0000_8001, 32'h0001_2345, 1'b0, 1'b0, -1);
    check("s0_name0", {24'b0, cap[0]}, "S");
    check("s0_name10", {24'b0, cap[10]}, "T");
    check("s0_attr", {24'b0, cap[11]}, 32'h20);
    check("s0_lo", {16'b0, cap[27], cap[26]}, 32'h8001);
    check("s0_size", {cap[31], cap[30], cap[29], cap[28]}, 32'h0001_2345);

    run_sector(4'd15, 32'hF123_4567, 32'h0000_0200, 1'b0, 1'b0, -1);
    check("s15_hi", {16'b0, cap[501], cap[500]}, 32'h0123);
    check("s15_lo", {16'b0, cap[507], cap[506]}, 32'h4567);

    for (int t = 0; t < 3; t++)
      run_sector(4'($urandom), $urandom, $urandom, 1'b1, 1'b1, -1);

    run_sector(4'd6, 32'h0ABC_DEF0, 32'h0000_1000, 1'b1, 1'b0, 200);
    run_sector(4'd9, 32'h0000_0042, 32'h00FE_DCBA, 1'b1, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
